// File: rtl/wbu_commit.sv
`default_nettype none
// ============================================================================
// Module   : wbu_commit
// Purpose  : Write-back/commit stage: GPR file, machine CSRs, next-PC select.
//            Optional 64-bit minstret counter under WBU_MINSTRET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wbu_commit #(
    parameter int                  DATA_LEN = 32,
    parameter int                  ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic                clock,
    input  logic                rstn,
    input  logic                lsu_valid_i,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic [2:0]          csr_type_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [ADDR_LEN-1:0] dnpc_i,
    input  logic [4:0]          raddr1_i,
    input  logic [4:0]          raddr2_i,
    output logic [DATA_LEN-1:0] rdata1_o,
    output logic [DATA_LEN-1:0] rdata2_o,
    input  logic [11:0]         csr_raddr_i,
    output logic [DATA_LEN-1:0] csr_rdata_o,
    output logic                wb_valid_o,
    output logic [ADDR_LEN-1:0] next_pc_o
);

    localparam logic [2:0]  c_CSR_WRITE = 3'b001;
    localparam logic [2:0]  c_CSR_ECALL = 3'b010;
    localparam logic [2:0]  c_CSR_MRET  = 3'b011;
    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_COMMIT = 2'd1,
        WB_DONE   = 2'd2
    } wb_state_t;

    wb_state_t             r_state;
    logic                  r_wb_valid;
    logic [ADDR_LEN-1:0]   r_next_pc;
    logic                  r_wd;
    logic [4:0]            r_wreg;
    logic [DATA_LEN-1:0]   r_wdata;
    logic [2:0]            r_csr_type;
    logic [11:0]           r_csr_addr;
    logic [DATA_LEN-1:0]   r_csr_wdata;
    logic [ADDR_LEN-1:0]   r_pc;
    logic [ADDR_LEN-1:0]   r_dnpc;
    logic [DATA_LEN-1:0]   r_gpr [0:31];
    logic [DATA_LEN-1:0]   r_mstatus;
    logic [DATA_LEN-1:0]   r_mtvec;
    logic [DATA_LEN-1:0]   r_mepc;
    logic [DATA_LEN-1:0]   r_mcause;
    logic                  w_commit;

    assign w_commit = (r_state == WB_COMMIT);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state     <= WB_IDLE;
            r_wb_valid  <= 1'b0;
            r_next_pc   <= RESET_PC;
            r_wd        <= 1'b0;
            r_wreg      <= '0;
            r_wdata     <= '0;
            r_csr_type  <= '0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_pc        <= '0;
            r_dnpc      <= '0;
        end else begin
            case (r_state)
                WB_IDLE: begin
                    r_wb_valid <= 1'b0;
                    if (lsu_valid_i) begin
                        r_wd        <= wd_i;
                        r_wreg      <= wreg_i;
                        r_wdata     <= wdata_i;
                        r_csr_type  <= csr_type_i;
                        r_csr_addr  <= csr_addr_i;
                        r_csr_wdata <= csr_wdata_i;
                        r_pc        <= pc_i;
                        r_dnpc      <= dnpc_i;
                        r_state     <= WB_COMMIT;
                    end
                end
                WB_COMMIT: begin
                    case (r_csr_type)
                        c_CSR_ECALL: r_next_pc <= ADDR_LEN'(r_mtvec);
                        c_CSR_MRET:  r_next_pc <= ADDR_LEN'(r_mepc);
                        default:     r_next_pc <= r_dnpc;
                    endcase
                    r_wb_valid <= 1'b1;
                    r_state    <= WB_DONE;
                end
                WB_DONE: begin
                    r_wb_valid <= 1'b0;
                    r_state    <= WB_IDLE;
                end
                default: begin
                    r_wb_valid <= 1'b0;
                    r_state    <= WB_IDLE;
                end
            endcase
        end
    end

    // x0 is never written, so it reads zero without a special read case
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
        end else if (w_commit && r_wd && (r_wreg != 5'd0)) begin
            r_gpr[r_wreg] <= r_wdata;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_mstatus <= DATA_LEN'(32'h0000_1800);
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else if (w_commit) begin
            if (r_csr_type == c_CSR_WRITE) begin
                case (r_csr_addr)
                    c_MSTATUS: r_mstatus <= r_csr_wdata;
                    c_MTVEC:   r_mtvec   <= r_csr_wdata;
                    c_MEPC:    r_mepc    <= r_csr_wdata;
                    c_MCAUSE:  r_mcause  <= r_csr_wdata;
                    default:   ;
                endcase
            end else if (r_csr_type == c_CSR_ECALL) begin
                r_mepc   <= DATA_LEN'(r_pc);
                r_mcause <= DATA_LEN'(11);
            end
        end
    end

`ifdef WBU_MINSTRET_EN
    logic [63:0] r_minstret;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_minstret <= '0;
        end else if (w_commit) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end
`endif

    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            c_MSTATUS: csr_rdata_o = r_mstatus;
            c_MTVEC:   csr_rdata_o = r_mtvec;
            c_MEPC:    csr_rdata_o = r_mepc;
            c_MCAUSE:  csr_rdata_o = r_mcause;
`ifdef WBU_MINSTRET_EN
            12'hB02:   csr_rdata_o = DATA_LEN'(r_minstret[31:0]);
            12'hB82:   csr_rdata_o = DATA_LEN'(r_minstret[63:32]);
`endif
            default:   csr_rdata_o = '0;
        endcase
    end

    assign rdata1_o   = r_gpr[raddr1_i];
    assign rdata2_o   = r_gpr[raddr2_i];
    assign wb_valid_o = r_wb_valid;
    assign next_pc_o  = r_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_wbu_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbu_commit
// Purpose  : Directed self-checking bench for wbu_commit with a next-PC
//            scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbu_commit;

    localparam logic [31:0] c_RESET_PC = 32'h3000_0000;
`ifdef WBU_MINSTRET_EN
    localparam logic [31:0] c_EXP_MINSTRET = 32'd3;
`else
    localparam logic [31:0] c_EXP_MINSTRET = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        rstn = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        wd_i = 1'b0;
    logic [4:0]  wreg_i = '0;
    logic [31:0] wdata_i = '0;
    logic [2:0]  csr_type_i = '0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] dnpc_i = '0;
    logic [4:0]  raddr1_i = '0;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic [11:0] csr_raddr_i = '0;
    logic [31:0] csr_rdata_o;
    logic        wb_valid_o;
    logic [31:0] next_pc_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int r_busy = 0;
    logic [31:0] r_sb [$];

    wbu_commit #(
        .DATA_LEN (32),
        .ADDR_LEN (32),
        .RESET_PC (c_RESET_PC)
    ) u_dut (
        .clock       (clock),
        .rstn        (rstn),
        .lsu_valid_i (lsu_valid_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .csr_type_i  (csr_type_i),
        .csr_addr_i  (csr_addr_i),
        .csr_wdata_i (csr_wdata_i),
        .pc_i        (pc_i),
        .dnpc_i      (dnpc_i),
        .raddr1_i    (raddr1_i),
        .raddr2_i    (raddr2_i),
        .rdata1_o    (rdata1_o),
        .rdata2_o    (rdata2_o),
        .csr_raddr_i (csr_raddr_i),
        .csr_rdata_o (csr_rdata_o),
        .wb_valid_o  (wb_valid_o),
        .next_pc_o   (next_pc_o)
    );

    always #5 clock = ~clock;

    // The stage is busy for two cycles after each accepted pulse
    always @(posedge clock) begin
        if (!rstn) begin
            r_busy = 0;
        end else begin
            assert (!(lsu_valid_i && r_busy != 0)) else begin
                n_fail++;
                $error("FAIL protocol: lsu_valid_i=1 while busy=%0d, required idle", r_busy);
            end
            if (lsu_valid_i)      r_busy = 2;
            else if (r_busy != 0) r_busy = r_busy - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_raddr_i = addr;
        #1;
        check(tag, csr_rdata_o, exp);
    endtask

    task automatic commit(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                          input logic [2:0] ctype, input logic [11:0] caddr,
                          input logic [31:0] cwdata, input logic [31:0] pc,
                          input logic [31:0] dnpc, input logic [31:0] exp_pc,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int lat;
        logic [31:0] exp_q;
        @(negedge clock);
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; csr_type_i = ctype;
        csr_addr_i = caddr; csr_wdata_i = cwdata; pc_i = pc; dnpc_i = dnpc;
        lsu_valid_i = 1'b1;
        r_sb.push_back(exp_pc);
        @(negedge clock);
        lsu_valid_i = 1'b0;
        wd_i = 1'b0; wreg_i = '0; wdata_i = '0; csr_type_i = '0;
        csr_addr_i = '0; csr_wdata_i = '0; pc_i = '0; dnpc_i = '0;
        lat = 1;
        while (!wb_valid_o && lat < 6) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'd2);
        check("wb_valid", {31'd0, wb_valid_o}, 32'd1);
        exp_q = (r_sb.size() > 0) ? r_sb.pop_front() : 32'hxxxx_xxxx;
        check("next_pc", next_pc_o, exp_q);
        if (chk_rd) check("rdata1_at_done", rdata1_o, exp_rd);
        @(negedge clock);
        check("pulse_width", {31'd0, wb_valid_o}, 32'd0);
    endtask

    initial begin
        // Reset and idle
        raddr1_i = 5'd7; raddr2_i = 5'd31;
        repeat (3) @(negedge clock);
        rstn = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_next_pc", next_pc_o, c_RESET_PC);
        check("reset_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("reset_rdata1", rdata1_o, 32'd0);
        check("reset_rdata2", rdata2_o, 32'd0);
        csr_check("reset_mstatus", 12'h300, 32'h0000_1800);
        csr_check("reset_mtvec", 12'h305, 32'd0);

        // Plain GPR write
        raddr1_i = 5'd5;
        commit(1'b1, 5'd5, 32'hDEAD_BEEF, 3'b000, 12'h0, 32'h0, 32'h3000_0000,
               32'h3000_0004, 32'h3000_0004, 1'b1, 32'hDEAD_BEEF);

        // x0 write dropped
        raddr1_i = 5'd0;
        commit(1'b1, 5'd0, 32'h0000_1234, 3'b000, 12'h0, 32'h0, 32'h3000_0004,
               32'h3000_0008, 32'h3000_0008, 1'b1, 32'd0);
        raddr2_i = 5'd5;
        #1 check("gpr5_held", rdata2_o, 32'hDEAD_BEEF);

        // GPR and CSR write in one instruction
        raddr1_i = 5'd6;
        commit(1'b1, 5'd6, 32'h5555_0000, 3'b001, 12'h305, 32'h8000_0100,
               32'h3000_0008, 32'h3000_000C, 32'h3000_000C, 1'b1, 32'h5555_0000);
        csr_check("mtvec_written", 12'h305, 32'h8000_0100);

        // ecall then mret
        commit(1'b0, 5'd0, 32'h0, 3'b010, 12'h0, 32'h0, 32'h8000_0040,
               32'h8000_0044, 32'h8000_0100, 1'b0, 32'd0);
        csr_check("mepc_ecall", 12'h341, 32'h8000_0040);
        csr_check("mcause_ecall", 12'h342, 32'd11);
        commit(1'b0, 5'd0, 32'h0, 3'b011, 12'h0, 32'h0, 32'h8000_0100,
               32'h8000_0104, 32'h8000_0040, 1'b0, 32'd0);
        csr_check("mstatus_after_mret", 12'h300, 32'h0000_1800);

        // Unimplemented CSR write ignored; reserved csr_type behaves as none
        commit(1'b0, 5'd0, 32'h0, 3'b001, 12'h123, 32'hFFFF_FFFF, 32'h8000_0040,
               32'h8000_0044, 32'h8000_0044, 1'b0, 32'd0);
        csr_check("unimpl_csr", 12'h123, 32'd0);
        commit(1'b0, 5'd0, 32'h0, 3'b111, 12'h305, 32'h0BAD_0BAD, 32'h8000_0044,
               32'h8000_0048, 32'h8000_0048, 1'b0, 32'd0);
        csr_check("mtvec_untouched", 12'h305, 32'h8000_0100);

        // Reset during COMMIT drops the pending write
        @(negedge clock);
        wd_i = 1'b1; wreg_i = 5'd3; wdata_i = 32'h0000_AAAA; dnpc_i = 32'h8000_004C;
        lsu_valid_i = 1'b1;
        @(negedge clock);
        lsu_valid_i = 1'b0;
        rstn = 1'b0;
        #1 check("abort_wb_valid_in_reset", {31'd0, wb_valid_o}, 32'd0);
        repeat (2) @(negedge clock);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_pulse", {31'd0, wb_valid_o}, 32'd0);
        end
        raddr1_i = 5'd3;
        #1 check("abort_gpr3", rdata1_o, 32'd0);
        check("abort_next_pc", next_pc_o, c_RESET_PC);
        csr_check("abort_mtvec", 12'h305, 32'd0);

        // Retired-instruction counter over three commits
        for (int i = 0; i < 3; i++) begin
            commit(1'b0, 5'd0, 32'h0, 3'b000, 12'h0, 32'h0, 32'h3000_0000 + 32'(4 * i),
                   32'h3000_0004 + 32'(4 * i), 32'h3000_0004 + 32'(4 * i), 1'b0, 32'd0);
        end
        csr_check("minstret_lo", 12'hB02, c_EXP_MINSTRET);
        csr_check("minstret_hi", 12'hB82, 32'd0);
        check("scoreboard_empty", 32'(r_sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
- Write-back/commit stage directly downstream of the load/store unit.
- Captures the LSU result on its one-cycle valid pulse and commits the GPR write, CSR write, ecall or mret.
- Computes the next fetch PC and signals the IFU with a one-cycle wb_valid pulse.
- Contains the 32x32 GPR file and the machine-mode CSRs (mstatus, mtvec, mepc, mcause), with combinational read ports for IDU/EXU.

Parameters:
DATA_LEN, 32, register/CSR data width
ADDR_LEN, 32, PC width
RESET_PC, 32'h3000_0000, next_pc_o value out of reset (flash base)

Ports:
clock  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
lsu_valid_i  in  1  one-cycle pulse from LSU: result fields valid this cycle only
wd_i  in  1  GPR write enable
wreg_i  in  5  GPR destination index
wdata_i  in  DATA_LEN  GPR write data (load data or ALU result, old CSR value for csrr*)
csr_type_i  in  3  000 none, 001 CSR write, 010 ecall, 011 mret, others treated as none
csr_addr_i  in  12  CSR address for write
csr_wdata_i  in  DATA_LEN  CSR write data (already merged for rs/rc by EXU)
pc_i  in  ADDR_LEN  PC of the committing instruction
dnpc_i  in  ADDR_LEN  non-trap next PC from EXU (pc+4 or branch/jump target)
raddr1_i  in  5  GPR read index 1
raddr2_i  in  5  GPR read index 2
rdata1_o  out  DATA_LEN  GPR read data 1, combinational
rdata2_o  out  DATA_LEN  GPR read data 2, combinational
csr_raddr_i  in  12  CSR read address
csr_rdata_o  out  DATA_LEN  CSR read data, combinational
wb_valid_o  out  1  one-cycle pulse: commit done, next_pc_o valid
next_pc_o  out  ADDR_LEN  next fetch PC, held until next commit

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to WB_IDLE and wb_valid_o=0.
  - next_pc_o=RESET_PC.
  - All GPRs are 0.
  - mstatus=32'h0000_1800; mtvec, mepc and mcause are 0.
  - A reset asserted mid-commit drops the pending commit entirely.
- States:
  - WB_IDLE: waits for lsu_valid_i.
  - WB_COMMIT: performs the writes.
  - WB_DONE: drives wb_valid_o.
- Transitions: IDLE→COMMIT on lsu_valid_i, COMMIT→DONE unconditionally, DONE→IDLE unconditionally.
- Latch: on the lsu_valid_i cycle (N), all input fields are latched into internal registers; the inputs need not be held after N.
- Cycle N+1 (COMMIT), at the clock edge:
  - GPR[wreg] <= wdata if wd=1 and wreg!=0. Writes to x0 are dropped; x0 always reads 0.
  - csr_type 001: the addressed CSR <= csr_wdata. Unimplemented addresses: write ignored.
  - csr_type 010 (ecall): mepc <= pc, mcause <= 32'd11, next_pc_o <= mtvec.
  - csr_type 011 (mret): next_pc_o <= mepc; mstatus is unchanged.
  - Otherwise: next_pc_o <= dnpc.
  - A GPR write and a CSR write in the same instruction both commit at the same edge.
- Cycle N+2 (DONE): wb_valid_o=1 for exactly one cycle; next_pc_o already reflects this commit.
- Latency: lsu_valid_i to wb_valid_o is exactly 2 cycles.
- lsu_valid_i while not in WB_IDLE: ignored, no state change. This is a protocol violation; the bench asserts it never occurs.
- Read ports:
  - Purely combinational with no write bypass; a write becomes visible the cycle after the COMMIT edge.
  - Unimplemented CSR reads return 0.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.

Optional Feature:
- Macro: WBU_MINSTRET_EN.
- Defined:
  - Adds a 64-bit retired-instruction counter, reset to 0.
  - Increments by 1 on every COMMIT cycle and wraps from 2^64-1 to 0.
  - Readable at 0xB02 (low word) and 0xB82 (high word); CSR writes to these addresses are ignored.
- Undefined: no counter logic; reads of 0xB02/0xB82 return 0 like any unimplemented CSR.

Test Plan:
- Reset, then idle → next_pc_o=32'h3000_0000, wb_valid_o=0, rdata of any index=0, csr_rdata(0x300)=32'h1800.
- Pulse lsu_valid_i with wd=1, wreg=5, wdata=32'hDEAD_BEEF, dnpc=32'h3000_0004 → wb_valid_o high exactly at N+2 for one cycle; next_pc_o=32'h3000_0004; rdata1 at raddr 5 = 32'hDEAD_BEEF from N+2.
- Commit wd=1, wreg=0, wdata=32'h1234 → raddr 0 still reads 0.
- Write mtvec=32'h8000_0100 via csr_type 001, then ecall at pc=32'h8000_0040 → mepc=32'h8000_0040, mcause=11, next_pc_o=32'h8000_0100; then mret → next_pc_o=32'h8000_0040.
- Assert rstn low during WB_COMMIT with wd=1, wreg=3 → GPR3 stays 0, no wb_valid_o pulse, next_pc_o=RESET_PC.
- With WBU_MINSTRET_EN defined: 3 commits → csr_rdata(0xB02)=3, (0xB82)=0; without the macro → both read 0.
